// File: rtl/bd_pkg.sv
// Shared types and constants for the baggage-drop hatch sequencer.
// State encodings are visible on state_dbg, so their values are fixed.
package bd_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_OPEN  = 3'd2,
    S_CLOSE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int UNITS_W = 16;
  localparam int COUNT_W = 8;

  localparam int DEF_CYCLES_PER_UNIT = 1000;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CLOSE_CYCLES    = 16;

  localparam logic [COUNT_W-1:0] DROP_COUNT_MAX = 8'd255;

  // A zero fall time still opens the hatch for one unit.
  function automatic logic [UNITS_W-1:0] clamp_units(input logic [UNITS_W-1:0] t);
    return (t == '0) ? UNITS_W'(1) : t;
  endfunction

endpackage

// File: rtl/drop_sequencer_if.sv
// Decision inputs from baggage_drop and hatch status outputs of the sequencer.
interface drop_sequencer_if;
  import bd_pkg::*;

  logic               drop_en;
  logic               drop_activated;
  logic [UNITS_W-1:0] t_act;
  logic               hatch_open;
  logic               busy;
  logic               done;
  logic               aborted;
  logic [COUNT_W-1:0] drop_count;
  logic [2:0]         state_dbg;

  modport master (
    output drop_en, drop_activated, t_act,
    input  hatch_open, busy, done, aborted, drop_count, state_dbg
  );

  modport slave (
    input  drop_en, drop_activated, t_act,
    output hatch_open, busy, done, aborted, drop_count, state_dbg
  );
endinterface

// File: rtl/unit_timer.sv
// Prescaler plus 16-bit unit down-counter; expired_o flags the final unit's last cycle.
module unit_timer
  import bd_pkg::*;
#(
    parameter int CYCLES_PER_UNIT = DEF_CYCLES_PER_UNIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [UNITS_W-1:0] units_i,
    input  logic               en_i,
    output logic               expired_o
);

    localparam int PW = $clog2(CYCLES_PER_UNIT) + 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_UNIT - 1);

    logic [PW-1:0]      presc_q;
    logic [UNITS_W-1:0] units_q;
    logic               wrap;

    assign wrap      = (presc_q == PRESC_LAST);
    assign expired_o = en_i && wrap && (units_q == UNITS_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            units_q <= '0;
        end else if (load_i) begin
            presc_q <= '0;
            units_q <= units_i;
        end else if (en_i) begin
            if (wrap) begin
                presc_q <= '0;
                // Holding at 1 keeps the counter from ever wrapping.
                if (units_q != UNITS_W'(1)) units_q <= units_q - UNITS_W'(1);
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/drop_sequencer.sv
// Timed hatch controller: debounce, open for t_act units, fixed close, then wait
// for drop_en to fall so that each enable assertion yields at most one drop.
module drop_sequencer
  import bd_pkg::*;
#(
    parameter int CYCLES_PER_UNIT = DEF_CYCLES_PER_UNIT,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CLOSE_CYCLES    = DEF_CLOSE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    drop_sequencer_if.slave  bus
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int CW = $clog2(CLOSE_CYCLES) + 1;
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CLOSE_LAST = CW'(CLOSE_CYCLES - 1);

    state_e             state_q;
    logic [DW-1:0]      deb_q;
    logic [CW-1:0]      close_q;
    logic               hatch_q;
    logic               busy_q;
    logic               done_q;
    logic               aborted_q;
    logic [COUNT_W-1:0] count_q;

    logic arm_ok;
    logic arm_fire;
    logic expired;

    assign arm_ok   = bus.drop_activated && bus.drop_en;
    assign arm_fire = (state_q == S_ARM) && arm_ok && (deb_q >= DEB_LAST);

    unit_timer #(
        .CYCLES_PER_UNIT(CYCLES_PER_UNIT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (arm_fire),
        .units_i   (clamp_units(bus.t_act)),
        .en_i      (state_q == S_OPEN),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            deb_q     <= '0;
            close_q   <= '0;
            hatch_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            count_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.drop_activated) begin
                        state_q   <= S_ARM;
                        deb_q     <= DW'(1);
                        busy_q    <= 1'b1;
                        aborted_q <= 1'b0;
                    end
                end
                S_ARM: begin
                    // Losing the request while debouncing is a glitch, not an abort.
                    if (!arm_ok) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (arm_fire) begin
                        state_q <= S_OPEN;
                        hatch_q <= 1'b1;
                    end else begin
                        deb_q <= deb_q + DW'(1);
                    end
                end
                S_OPEN: begin
                    if (!bus.drop_en || expired) begin
                        state_q <= S_CLOSE;
                        hatch_q <= 1'b0;
                        close_q <= '0;
                        if (!bus.drop_en) aborted_q <= 1'b1;
                    end
                end
                S_CLOSE: begin
                    if (close_q == CLOSE_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        if (!aborted_q) begin
                            done_q <= 1'b1;
                            if (count_q != DROP_COUNT_MAX) count_q <= count_q + COUNT_W'(1);
                        end
                    end else begin
                        close_q <= close_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (!bus.drop_en) state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    hatch_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hatch_open = hatch_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.aborted    = aborted_q;
    assign bus.drop_count = count_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_drop_sequencer.sv
// Directed bench for drop_sequencer with CYCLES_PER_UNIT=4, DEBOUNCE_CYCLES=2, CLOSE_CYCLES=3.
module tb_drop_sequencer;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;
    int   exp_count;

    drop_sequencer_if bus ();

    drop_sequencer #(
        .CYCLES_PER_UNIT(4),
        .DEBOUNCE_CYCLES(2),
        .CLOSE_CYCLES   (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One complete drop from IDLE back to IDLE; chg >= 0 rewrites t_act mid-OPEN.
    task automatic run_drop(input logic [15:0] t, input int chg, input int exp_open, input bit hold);
        int n;
        chk("start_idle", 32'(bus.state_dbg), 0);
        bus.drop_en        = 1'b1;
        bus.drop_activated = 1'b1;
        bus.t_act          = t;
        tick();
        chk("arm_state", 32'(bus.state_dbg), 1);
        chk("arm_aborted", 32'(bus.aborted), 0);
        tick();
        chk("arm_hatch", 32'(bus.hatch_open), 0);
        tick();
        chk("open_start", 32'(bus.hatch_open), 1);
        bus.drop_activated = 1'b0;
        if (chg >= 0) bus.t_act = 16'(chg);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            if (!bus.hatch_open) break;
            n++;
            tick();
        end
        chk("open_len", 32'(n), 32'(exp_open));
        chk("close_state", 32'(bus.state_dbg), 3);
        chk("close_busy", 32'(bus.busy), 1);
        tick();
        tick();
        chk("close_no_done", 32'(bus.done), 0);
        tick();
        chk("done_pulse", 32'(bus.done), 1);
        chk("done_state", 32'(bus.state_dbg), 4);
        exp_count = (exp_count == 255) ? 255 : exp_count + 1;
        chk("drop_count", 32'(bus.drop_count), 32'(exp_count));
        tick();
        chk("done_single", 32'(bus.done), 0);
        if (hold) begin
            bus.drop_activated = 1'b1;
            repeat (6) tick();
            chk("hold_state", 32'(bus.state_dbg), 4);
            chk("hold_hatch", 32'(bus.hatch_open), 0);
            chk("hold_count", 32'(bus.drop_count), 32'(exp_count));
        end
        bus.drop_en        = 1'b0;
        bus.drop_activated = 1'b0;
        tick();
        chk("back_idle", 32'(bus.state_dbg), 0);
    endtask

    initial begin
        vectors   = 0;
        errors    = 0;
        exp_count = 0;
        rst_n              = 1'b0;
        bus.drop_en        = 1'b0;
        bus.drop_activated = 1'b0;
        bus.t_act          = 16'd0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_state", 32'(bus.state_dbg), 0);
        chk("rst_hatch", 32'(bus.hatch_open), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_aborted", 32'(bus.aborted), 0);
        chk("rst_count", 32'(bus.drop_count), 0);

        // Nominal: 5 units x 4 cycles, then hold drop_en to prove one drop per enable.
        run_drop(16'd5, -1, 20, 1'b1);

        // Single-cycle glitch on drop_activated.
        bus.drop_en        = 1'b1;
        bus.drop_activated = 1'b1;
        tick();
        chk("glitch_arm", 32'(bus.state_dbg), 1);
        bus.drop_activated = 1'b0;
        tick();
        chk("glitch_idle", 32'(bus.state_dbg), 0);
        chk("glitch_busy", 32'(bus.busy), 0);
        repeat (4) tick();
        chk("glitch_hatch", 32'(bus.hatch_open), 0);
        chk("glitch_aborted", 32'(bus.aborted), 0);
        bus.drop_en = 1'b0;
        tick();

        // Abort: drop_en falls after the sixth OPEN cycle.
        bus.drop_en        = 1'b1;
        bus.drop_activated = 1'b1;
        bus.t_act          = 16'd5;
        repeat (3) tick();
        chk("abort_open", 32'(bus.hatch_open), 1);
        repeat (5) tick();
        chk("abort_open6", 32'(bus.hatch_open), 1);
        bus.drop_en        = 1'b0;
        bus.drop_activated = 1'b0;
        tick();
        chk("abort_hatch", 32'(bus.hatch_open), 0);
        chk("abort_state", 32'(bus.state_dbg), 3);
        chk("abort_flag", 32'(bus.aborted), 1);
        tick();
        chk("abort_close1_done", 32'(bus.done), 0);
        tick();
        chk("abort_close2_state", 32'(bus.state_dbg), 3);
        chk("abort_close2_done", 32'(bus.done), 0);
        tick();
        chk("abort_done_state", 32'(bus.state_dbg), 4);
        chk("abort_no_pulse", 32'(bus.done), 0);
        chk("abort_count", 32'(bus.drop_count), 32'(exp_count));
        tick();
        chk("abort_idle", 32'(bus.state_dbg), 0);
        chk("abort_sticky", 32'(bus.aborted), 1);

        // t_act of zero opens for one unit; a mid-OPEN t_act change is ignored.
        run_drop(16'd0, -1, 4, 1'b0);
        run_drop(16'd2, 9, 8, 1'b0);

        // Saturation of the drop counter.
        for (int k = 0; k < 256; k++) run_drop(16'd1, -1, 4, 1'b0);
        chk("sat_count", 32'(bus.drop_count), 255);

        // Reset while the hatch is open.
        bus.drop_en        = 1'b1;
        bus.drop_activated = 1'b1;
        bus.t_act          = 16'd5;
        repeat (5) tick();
        chk("pre_rst_hatch", 32'(bus.hatch_open), 1);
        rst_n              = 1'b0;
        bus.drop_en        = 1'b0;
        bus.drop_activated = 1'b0;
        tick();
        chk("mid_rst_state", 32'(bus.state_dbg), 0);
        chk("mid_rst_hatch", 32'(bus.hatch_open), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_done", 32'(bus.done), 0);
        chk("mid_rst_aborted", 32'(bus.aborted), 0);
        chk("mid_rst_count", 32'(bus.drop_count), 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_state", 32'(bus.state_dbg), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/drop_sequencer.md
Name: drop_sequencer

Overview:
- Timed hatch controller directly downstream of the baggage_drop decision stage.
- Consumes its drop_activated flag and the computed fall time t_act. When a qualified drop request arrives, it opens the hatch for t_act time units, runs a fixed close phase, then holds in a done state until the operator drops drop_en.
- Provides debounce, abort, one-drop-per-enable and a saturating drop counter.

Parameters:
- CYCLES_PER_UNIT, 1000: clock cycles per t_act time unit (prescaler terminal count); must be >= 1.
- DEBOUNCE_CYCLES, 4: consecutive cycles drop_activated must be high before the hatch opens; must be >= 1.
- CLOSE_CYCLES, 16: cycles spent in the CLOSE state (hatch motor retract time).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- drop_en  input  1  operator enable, same signal fed to baggage_drop.
- drop_activated  input  1  decision from baggage_drop (t_act <= t_lim and drop_en).
- t_act  input  16  fall time in units, from baggage_drop.
- hatch_open  output  1  drives hatch actuator; high only in OPEN.
- busy  output  1  high in ARM, OPEN, CLOSE.
- done  output  1  single-cycle pulse on the CLOSE->DONE transition of a completed drop.
- aborted  output  1  sticky; set on abort, cleared when the next ARM is entered or on reset.
- drop_count  output  8  completed drops, saturates at 255.
- state_dbg  output  3  current state encoding.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces:
  - state=IDLE; hatch_open=0, busy=0, done=0, aborted=0, drop_count=0.
  - All internal counters cleared.
  - Reset wins over every other event, including mid-OPEN; the hatch closes the next cycle.
- IDLE: if drop_activated=1, go to ARM and set the debounce counter to 1. Otherwise stay.
- ARM:
  - drop_activated=1: increment the debounce counter.
  - Counter reaches DEBOUNCE_CYCLES: latch units_left = max(t_act, 1), go to OPEN. A t_act of 0 is treated as 1 unit.
  - drop_activated=0 or drop_en=0: return to IDLE. This is not an abort; aborted is unchanged.
- OPEN:
  - hatch_open=1.
  - The prescaler counts 0..CYCLES_PER_UNIT-1; on wrap, units_left decrements.
  - When units_left=1 and the prescaler wraps, go to CLOSE.
  - Open duration is exactly units_left_latched*CYCLES_PER_UNIT cycles.
  - t_act changes during OPEN are ignored (latched value only).
  - drop_en=0 during OPEN: abort. Set aborted=1 and go to CLOSE on the next edge; no done pulse and no count increment for this drop.
  - drop_activated dropping during OPEN is ignored.
- CLOSE:
  - hatch_open=0, busy=1. Lasts exactly CLOSE_CYCLES cycles; drop_en is ignored here.
  - Exit to DONE. If the drop was not aborted: pulse done for 1 cycle and increment drop_count (saturating at 255).
- DONE: busy=0. Wait for drop_en=0, then go to IDLE. This enforces one drop per enable assertion; drop_activated is ignored while in DONE.
- Latency: the first hatch_open=1 cycle occurs DEBOUNCE_CYCLES+1 edges after drop_activated first samples high.
- Widths:
  - units_left is 16 bits.
  - The prescaler is sized by $clog2(CYCLES_PER_UNIT)+1.
  - The close counter is sized by $clog2(CLOSE_CYCLES)+1.
  - No wraparound is possible, since units_left stops at 1.
- All outputs are registered.

Decomposition:
- Shared package bd_pkg holds:
  - the state typedef (IDLE=0, ARM=1, OPEN=2, CLOSE=3, DONE=4);
  - the default parameter constants;
  - the DROP_COUNT_MAX=255 constant.
- One natural sub-module: unit_timer, the prescaler plus 16-bit down-counter, with load, enable and expired ports.
- The FSM stays in the top module.

Test Plan (benches use CYCLES_PER_UNIT=4, DEBOUNCE_CYCLES=2, CLOSE_CYCLES=3):
- Nominal drop: drop_en=1, drop_activated=1, t_act=5 -> hatch_open high for exactly 20 cycles starting 3 edges after the request; done pulses once after 3 CLOSE cycles; drop_count=1.
- Glitch rejection: drop_activated high for 1 cycle only -> ARM then IDLE; hatch_open never asserts; aborted=0.
- Abort: drop_en falls in cycle 6 of OPEN -> hatch_open=0 on the next edge; CLOSE lasts 3 cycles; aborted=1, no done pulse, drop_count unchanged.
- Zero and changing t_act: t_act=0 -> open 4 cycles. Separately, t_act=2 latched then changed to 9 mid-OPEN -> open 8 cycles.
- One-per-enable and saturation:
  - Hold drop_en=1 after done -> stays in DONE and no second drop.
  - Toggle drop_en 256 times with completed drops -> drop_count=255.
- Reset mid-OPEN: rst_n=0 for one edge -> the next cycle shows IDLE with all outputs 0, including drop_count.
